// File: rtl/midi_voice_allocator_pkg.sv
// midi_voice_allocator_pkg: shared MIDI field widths and allocator FSM state encoding
package midi_voice_allocator_pkg;

    localparam int MIDI_NOTE_BITS = 7;
    localparam int MIDI_VEL_BITS  = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/midi_voice_allocator_voice_slot.sv
// midi_voice_allocator_voice_slot: per-voice gate/note/velocity/age storage driven by allocator commands
module midi_voice_allocator_voice_slot
    import midi_voice_allocator_pkg::*;
#(
    parameter int AGE_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      write,
    input  logic                      rel,
    input  logic                      age_inc,
    input  logic [MIDI_NOTE_BITS-1:0] wr_note,
    input  logic [MIDI_VEL_BITS-1:0]  wr_velocity,
    output logic                      gate,
    output logic [MIDI_NOTE_BITS-1:0] note,
    output logic [MIDI_VEL_BITS-1:0]  velocity,
    output logic [AGE_BITS-1:0]       age
);

    // clear beats write; release keeps note/velocity so the envelope can finish its tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate     <= 1'b0;
            note     <= '0;
            velocity <= '0;
            age      <= '0;
        end else if (clear) begin
            gate <= 1'b0;
            age  <= '0;
        end else if (write) begin
            gate     <= 1'b1;
            note     <= wr_note;
            velocity <= wr_velocity;
            age      <= '0;
        end else begin
            if (rel)
                gate <= 1'b0;
            if (age_inc && gate && age != '1)
                age <= age + 1'b1;
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: maps note-on/off events onto voices (retrigger, lowest free, else steal oldest)
module midi_voice_allocator
    import midi_voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_BITS   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ev_valid,
    output logic                               ev_ready,
    input  logic                               ev_note_on,
    input  logic [MIDI_NOTE_BITS-1:0]          ev_note,
    input  logic [MIDI_VEL_BITS-1:0]           ev_velocity,
    input  logic                               all_notes_off,
    output logic [NUM_VOICES-1:0]              voice_gate,
    output logic [MIDI_NOTE_BITS*NUM_VOICES-1:0] voice_note,
    output logic [MIDI_VEL_BITS*NUM_VOICES-1:0]  voice_velocity,
    output logic [NUM_VOICES-1:0]              voice_trigger,
    output logic                               voice_stolen
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam int IW = $clog2(NUM_VOICES + 1);

    state_t                    state;
    logic [IW-1:0]             idx;
    logic                      ev_on;
    logic [MIDI_NOTE_BITS-1:0] ev_n;
    logic [MIDI_VEL_BITS-1:0]  ev_v;
    logic                      match_found, free_found, old_found;
    logic [VW-1:0]             match_idx, free_idx, old_idx, cur, target;
    logic [AGE_BITS-1:0]       old_age;
    logic                      resolve, steal;
    logic [NUM_VOICES-1:0]     gates, wr, rel, inc;
    logic [MIDI_NOTE_BITS-1:0] notes [NUM_VOICES];
    logic [MIDI_VEL_BITS-1:0]  vels  [NUM_VOICES];
    logic [AGE_BITS-1:0]       ages  [NUM_VOICES];

    // the cycle after the last voice is scanned resolves the target from the finished trackers
    assign cur      = idx[VW-1:0];
    assign resolve  = (state == ST_SCAN) && (idx == IW'(NUM_VOICES));
    assign steal    = !match_found && !free_found;
    assign target   = match_found ? match_idx : free_found ? free_idx : old_idx;
    assign ev_ready = (state == ST_IDLE);
    assign voice_gate = gates;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        assign wr[i]  = resolve && ev_on && (target == VW'(i));
        assign inc[i] = resolve && ev_on && (target != VW'(i));
        assign rel[i] = resolve && !ev_on && match_found && (match_idx == VW'(i));

        midi_voice_allocator_voice_slot #(.AGE_BITS(AGE_BITS)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .clear       (all_notes_off),
            .write       (wr[i]),
            .rel         (rel[i]),
            .age_inc     (inc[i]),
            .wr_note     (ev_n),
            .wr_velocity (ev_v),
            .gate        (gates[i]),
            .note        (notes[i]),
            .velocity    (vels[i]),
            .age         (ages[i])
        );

        assign voice_note[MIDI_NOTE_BITS*i +: MIDI_NOTE_BITS]    = notes[i];
        assign voice_velocity[MIDI_VEL_BITS*i +: MIDI_VEL_BITS]  = vels[i];
    end

    // allocator FSM: latch event, scan one voice per cycle, commit, with registered pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            ev_on         <= 1'b0;
            ev_n          <= '0;
            ev_v          <= '0;
            match_found   <= 1'b0;
            free_found    <= 1'b0;
            old_found     <= 1'b0;
            match_idx     <= '0;
            free_idx      <= '0;
            old_idx       <= '0;
            old_age       <= '0;
            voice_trigger <= '0;
            voice_stolen  <= 1'b0;
        end else if (all_notes_off) begin
            state         <= ST_IDLE;
            idx           <= '0;
            voice_trigger <= '0;
            voice_stolen  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    voice_trigger <= '0;
                    voice_stolen  <= 1'b0;
                    if (ev_valid) begin
                        ev_on       <= ev_note_on && (ev_velocity != '0);
                        ev_n        <= ev_note;
                        ev_v        <= ev_velocity;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        match_idx   <= '0;
                        free_idx    <= '0;
                        old_idx     <= '0;
                        old_age     <= '0;
                        state       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (resolve) begin
                        voice_trigger <= wr;
                        voice_stolen  <= ev_on && steal;
                        state         <= ST_COMMIT;
                    end else begin
                        if (!match_found && gates[cur] && notes[cur] == ev_n) begin
                            match_found <= 1'b1;
                            match_idx   <= cur;
                        end
                        if (!free_found && !gates[cur]) begin
                            free_found <= 1'b1;
                            free_idx   <= cur;
                        end
                        if (gates[cur] && (!old_found || ages[cur] > old_age)) begin
                            old_found <= 1'b1;
                            old_idx   <= cur;
                            old_age   <= ages[cur];
                        end
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    voice_trigger <= '0;
                    voice_stolen  <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: directed scenario tests for the MIDI voice allocator
module tb_midi_voice_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_note_on;
    logic [6:0]  ev_note;
    logic [6:0]  ev_velocity;
    logic        all_notes_off;
    logic [3:0]  voice_gate;
    logic [27:0] voice_note;
    logic [27:0] voice_velocity;
    logic [3:0]  voice_trigger;
    logic        voice_stolen;

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;
    int steal_cnt = 0;

    midi_voice_allocator #(.NUM_VOICES(4), .AGE_BITS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_note_on     (ev_note_on),
        .ev_note        (ev_note),
        .ev_velocity    (ev_velocity),
        .all_notes_off  (all_notes_off),
        .voice_gate     (voice_gate),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_trigger  (voice_trigger),
        .voice_stolen   (voice_stolen)
    );

    always #5 clk = ~clk;

    // count pulse cycles as seen just before each rising edge
    always @(posedge clk) begin
        if (|voice_trigger) trig_cnt++;
        if (voice_stolen) steal_cnt++;
    end

    function automatic logic [6:0] nt(input int i);
        return voice_note[7*i +: 7];
    endfunction

    function automatic logic [6:0] vl(input int i);
        return voice_velocity[7*i +: 7];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ev_valid = 1'b0;
        ev_note_on = 1'b0;
        ev_note = '0;
        ev_velocity = '0;
        all_notes_off = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // present one event at a negedge while ready; returns at the negedge after the accepting edge
    task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
        ev_valid = 1'b1;
        ev_note_on = on;
        ev_note = n;
        ev_velocity = v;
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic play(input logic on, input logic [6:0] n, input logic [6:0] v);
        send(on, n, v);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ev_valid = 1'b0;
        ev_note_on = 1'b0;
        ev_note = '0;
        ev_velocity = '0;
        all_notes_off = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (voice_gate !== 4'b0000) begin errors++; $display("FAIL reset_gate: got %b expected 0000", voice_gate); end
        checks++;
        if (voice_note !== 28'd0 || voice_velocity !== 28'd0) begin errors++; $display("FAIL reset_note_vel: got %h/%h expected 0/0", voice_note, voice_velocity); end
        checks++;
        if (voice_trigger !== 4'b0000 || voice_stolen !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b/%b expected 0000/0", voice_trigger, voice_stolen); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ev_ready); end
    endtask

    task automatic test_first_note();
        int low;
        do_reset();
        trig_cnt = 0;
        low = 0;
        send(1'b1, 7'd60, 7'd100);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (!ev_ready) low++;
            if (k == 4) begin
                checks++;
                if (voice_gate !== 4'b0000) begin errors++; $display("FAIL first_early_gate: got %b expected 0000", voice_gate); end
            end
            if (k == 5) begin
                checks++;
                if (voice_gate !== 4'b0001) begin errors++; $display("FAIL first_gate: got %b expected 0001", voice_gate); end
                checks++;
                if (nt(0) !== 7'd60 || vl(0) !== 7'd100) begin errors++; $display("FAIL first_note_vel: got %0d/%0d expected 60/100", nt(0), vl(0)); end
                checks++;
                if (voice_trigger !== 4'b0001) begin errors++; $display("FAIL first_trigger: got %b expected 0001", voice_trigger); end
            end
            if (k == 6) begin
                checks++;
                if (voice_trigger !== 4'b0000) begin errors++; $display("FAIL first_trigger_end: got %b expected 0000", voice_trigger); end
            end
        end
        checks++;
        if (low != 6) begin errors++; $display("FAIL first_ready_low: got %0d cycles expected 6", low); end
        checks++;
        if (trig_cnt != 1) begin errors++; $display("FAIL first_trigger_count: got %0d expected 1", trig_cnt); end
    endtask

    task automatic test_steal();
        do_reset();
        play(1'b1, 7'd60, 7'd10);
        play(1'b1, 7'd62, 7'd20);
        play(1'b1, 7'd64, 7'd30);
        play(1'b1, 7'd67, 7'd40);
        checks++;
        if (voice_gate !== 4'b1111 || nt(1) !== 7'd62 || nt(3) !== 7'd67) begin
            errors++; $display("FAIL fill_voices: got gate %b n1 %0d n3 %0d expected 1111 62 67", voice_gate, nt(1), nt(3));
        end
        steal_cnt = 0;
        send(1'b1, 7'd72, 7'd90);
        repeat (5) @(negedge clk);
        checks++;
        if (voice_stolen !== 1'b1 || voice_trigger !== 4'b0001) begin errors++; $display("FAIL steal_pulse: got %b/%b expected 1/0001", voice_stolen, voice_trigger); end
        checks++;
        if (voice_gate !== 4'b1111 || nt(0) !== 7'd72 || vl(0) !== 7'd90 || nt(1) !== 7'd62) begin
            errors++; $display("FAIL steal_voice0: got gate %b n0 %0d v0 %0d n1 %0d expected 1111 72 90 62", voice_gate, nt(0), vl(0), nt(1));
        end
        @(negedge clk);
        checks++;
        if (steal_cnt != 1 || voice_stolen !== 1'b0) begin errors++; $display("FAIL steal_count: got %0d/%b expected 1/0", steal_cnt, voice_stolen); end
        send(1'b1, 7'd74, 7'd5);
        repeat (5) @(negedge clk);
        checks++;
        if (voice_trigger !== 4'b0010 || voice_stolen !== 1'b1 || nt(1) !== 7'd74 || nt(0) !== 7'd72) begin
            errors++; $display("FAIL steal_next_oldest: got trig %b stolen %b n1 %0d n0 %0d expected 0010 1 74 72", voice_trigger, voice_stolen, nt(1), nt(0));
        end
        @(negedge clk);
    endtask

    task automatic test_retrigger();
        do_reset();
        play(1'b1, 7'd60, 7'd100);
        trig_cnt = 0;
        steal_cnt = 0;
        send(1'b1, 7'd60, 7'd50);
        repeat (5) @(negedge clk);
        checks++;
        if (voice_trigger !== 4'b0001 || voice_gate !== 4'b0001 || vl(0) !== 7'd50 || voice_stolen !== 1'b0) begin
            errors++; $display("FAIL retrigger: got trig %b gate %b v0 %0d stolen %b expected 0001 0001 50 0", voice_trigger, voice_gate, vl(0), voice_stolen);
        end
        @(negedge clk);
        play(1'b1, 7'd60, 7'd0);
        checks++;
        if (voice_gate !== 4'b0000 || nt(0) !== 7'd60 || vl(0) !== 7'd50) begin
            errors++; $display("FAIL vel0_release: got gate %b n0 %0d v0 %0d expected 0000 60 50", voice_gate, nt(0), vl(0));
        end
        checks++;
        if (trig_cnt != 1 || steal_cnt != 0) begin errors++; $display("FAIL retrigger_pulses: got %0d/%0d expected 1/0", trig_cnt, steal_cnt); end
        play(1'b1, 7'd65, 7'd70);
        checks++;
        if (voice_gate !== 4'b0001 || nt(0) !== 7'd65) begin errors++; $display("FAIL reuse_free: got gate %b n0 %0d expected 0001 65", voice_gate, nt(0)); end
    endtask

    task automatic test_noop_off();
        int low;
        do_reset();
        play(1'b1, 7'd60, 7'd100);
        trig_cnt = 0;
        steal_cnt = 0;
        low = 0;
        send(1'b0, 7'd61, 7'd64);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (!ev_ready) low++;
        end
        checks++;
        if (voice_gate !== 4'b0001 || nt(0) !== 7'd60 || vl(0) !== 7'd100) begin
            errors++; $display("FAIL noop_off_state: got gate %b n0 %0d v0 %0d expected 0001 60 100", voice_gate, nt(0), vl(0));
        end
        checks++;
        if (trig_cnt != 0 || steal_cnt != 0) begin errors++; $display("FAIL noop_off_pulses: got %0d/%0d expected 0/0", trig_cnt, steal_cnt); end
        checks++;
        if (low != 6) begin errors++; $display("FAIL noop_off_ready: got %0d cycles expected 6", low); end
    endtask

    task automatic test_all_notes_off();
        do_reset();
        play(1'b1, 7'd60, 7'd10);
        play(1'b1, 7'd62, 7'd20);
        play(1'b1, 7'd64, 7'd30);
        play(1'b1, 7'd67, 7'd40);
        trig_cnt = 0;
        send(1'b1, 7'd70, 7'd70);
        @(negedge clk);
        all_notes_off = 1'b1;
        @(negedge clk);
        all_notes_off = 1'b0;
        checks++;
        if (voice_gate !== 4'b0000 || ev_ready !== 1'b1) begin errors++; $display("FAIL anf_scan: got gate %b ready %b expected 0000 1", voice_gate, ev_ready); end
        repeat (6) @(negedge clk);
        checks++;
        if (voice_gate !== 4'b0000 || trig_cnt != 0) begin errors++; $display("FAIL anf_dropped: got gate %b trig %0d expected 0000 0", voice_gate, trig_cnt); end
        play(1'b1, 7'd60, 7'd10);
        trig_cnt = 0;
        ev_valid = 1'b1;
        ev_note_on = 1'b1;
        ev_note = 7'd62;
        ev_velocity = 7'd20;
        all_notes_off = 1'b1;
        @(negedge clk);
        ev_valid = 1'b0;
        all_notes_off = 1'b0;
        checks++;
        if (voice_gate !== 4'b0000 || ev_ready !== 1'b1) begin errors++; $display("FAIL anf_same_edge: got gate %b ready %b expected 0000 1", voice_gate, ev_ready); end
        repeat (6) @(negedge clk);
        checks++;
        if (voice_gate !== 4'b0000 || trig_cnt != 0) begin errors++; $display("FAIL anf_same_edge_drop: got gate %b trig %0d expected 0000 0", voice_gate, trig_cnt); end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        play(1'b1, 7'd60, 7'd10);
        play(1'b1, 7'd62, 7'd20);
        send(1'b1, 7'd64, 7'd30);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (voice_gate !== 4'b0000 || voice_note !== 28'd0 || voice_velocity !== 28'd0) begin
            errors++; $display("FAIL async_reset: got gate %b note %h vel %h expected 0 0 0", voice_gate, voice_note, voice_velocity);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ev_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ev_ready); end
        send(1'b1, 7'd64, 7'd80);
        repeat (5) @(negedge clk);
        checks++;
        if (voice_gate !== 4'b0001 || nt(0) !== 7'd64 || vl(0) !== 7'd80 || voice_trigger !== 4'b0001) begin
            errors++; $display("FAIL post_reset_note: got gate %b n0 %0d v0 %0d trig %b expected 0001 64 80 0001", voice_gate, nt(0), vl(0), voice_trigger);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int acc [2];
        int n_acc;
        do_reset();
        n_acc = 0;
        acc[0] = 0;
        acc[1] = 0;
        ev_valid = 1'b1;
        ev_note_on = 1'b1;
        ev_note = 7'd50;
        ev_velocity = 7'd40;
        for (int c = 0; c < 30; c++) begin
            if (ev_valid && ev_ready && n_acc < 2) begin
                acc[n_acc] = c;
                n_acc++;
            end
            @(negedge clk);
            if (n_acc == 1) begin
                ev_note = 7'd52;
                ev_velocity = 7'd41;
            end
            if (n_acc == 2) ev_valid = 1'b0;
        end
        checks++;
        if (n_acc != 2 || acc[1] - acc[0] != 7) begin errors++; $display("FAIL b2b_spacing: got %0d accepts gap %0d expected 2 7", n_acc, acc[1] - acc[0]); end
        checks++;
        if (voice_gate !== 4'b0011 || nt(0) !== 7'd50 || nt(1) !== 7'd52 || vl(1) !== 7'd41) begin
            errors++; $display("FAIL b2b_voices: got gate %b n0 %0d n1 %0d v1 %0d expected 0011 50 52 41", voice_gate, nt(0), nt(1), vl(1));
        end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_steal();
        test_retrigger();
        test_noop_off();
        test_all_notes_off();
        test_reset_mid_scan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
